product_stream_unpacker: RTL and testbench
==========================================

Name: product_stream_unpacker

Overview:
- Receiving end of the flattened product-type bus used by the tuple registers and tuple muxes.
- Bus layout: field a0 (Bit) in bit 0; field a1 (SInt) in bits WIDTH_A1:1.
- Buffers packed words in a small FIFO with valid/ready handshakes on both sides and presents the unpacked a0/a1 fields.
- Holds a "last consumed" tuple register with a product-type reset value.

Parameters:
WIDTH_A1, 8, width of signed field a1; packed word width is WIDTH_A1+1
DEPTH, 2, FIFO entries (power of two, >= 2)
INIT_A0, 1, reset value of last_a0
INIT_A1, 2, reset value of last_a1 (WIDTH_A1-bit two's complement)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous reset, active-high
I_data  input  WIDTH_A1+1  packed tuple {a1, a0}
I_valid  input  1  producer offers I_data
I_ready  output  1  FIFO can accept a word
O_a0  output  1  head entry field a0
O_a1  output  WIDTH_A1  head entry field a1 (signed)
O_valid  output  1  head entry is valid
O_ready  input  1  consumer accepts head
last_a0  output  1  a0 of most recently popped tuple
last_a1  output  WIDTH_A1  a1 of most recently popped tuple
count  output  log2(DEPTH)+1  current occupancy
overflow  output  1  sticky: I_valid was high while I_ready was low

Behaviour:
- Reset (RESET=1 at a rising CLK edge): count=0, read and write pointers =0, O_valid=0, I_ready=1, last_a0=INIT_A0, last_a1=INIT_A1, overflow=0. Reset overrides any push or pop in the same cycle. Reset mid-stream discards all buffered entries. FIFO storage contents are don't-care.
- I_ready = (count != DEPTH). O_valid = (count != 0). Both are derived from registered count only; neither depends combinationally on I_valid or O_ready.
- push = I_valid & I_ready. pop = O_valid & O_ready.
- On push: mem[wptr] <= I_data; wptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- On pop: rptr increments modulo DEPTH; last_a0 <= mem[rptr][0]; last_a1 <= mem[rptr][WIDTH_A1:1].
- count: +1 on push only, -1 on pop only, unchanged on push & pop.
- O_a0 = mem[rptr][0]. O_a1 = mem[rptr][WIDTH_A1:1]. Both hold their value while O_valid=1 and O_ready=0. When O_valid=0 their value is don't-care.
- Latency: no fall-through. A word pushed at edge N is visible with O_valid=1 after edge N.
- Empty: push and pop cannot coincide because O_valid=0.
- Full: I_ready=0, so no push. A pop in the full cycle frees a slot, and I_ready rises the next cycle (no same-cycle bypass).
- Partially filled: simultaneous push and pop are both performed; count is unchanged.
- overflow sets when I_valid=1 and I_ready=0. It clears only on RESET.
- a1 is carried bit-exact; no sign extension or arithmetic is applied inside the block.

Test Plan:
1. Reset then idle -> O_valid=0, I_ready=1, count=0, last_a0=1, last_a1=8'h02, overflow=0.
2. Push I_data=9'h0FF (a0=1, a1=8'h7F) with O_ready=0 -> next cycle O_valid=1, O_a0=1, O_a1=8'h7F, count=1. Then O_ready=1 for one cycle -> last_a0=1, last_a1=8'h7F, count=0.
3. Push 9'h100 then 9'h003 with O_ready=0 -> count=2, I_ready=0. Hold I_valid=1 with 9'h1FE -> word rejected, overflow=1. Pop twice -> outputs (a0=0, a1=8'h80) then (a0=1, a1=8'h01). last_a1=8'h01.
4. Continuous streaming, I_valid=O_ready=1, 10 words 9'h000..9'h009 -> in-order output, count settles at 1, pointers wrap correctly past DEPTH.
5. Fill FIFO, then assert RESET together with a pop -> count=0, O_valid=0, last_a1=8'h02 (pop suppressed).
6. Full FIFO with pop and I_valid in the same cycle -> input not accepted that cycle; I_ready=1 next cycle; word accepted on the following edge.

Source files
------------

// File: rtl/product_stream_unpacker.sv
// Unpacks {a1,a0} product words through a DEPTH-entry FIFO; a pushed word is visible the cycle after its edge.
// I_ready/O_valid derive from registered occupancy only; last_a0/last_a1 capture each popped tuple.
module product_stream_unpacker #(
  parameter int WIDTH_A1 = 8,
  parameter int DEPTH    = 2,
  parameter int INIT_A0  = 1,
  parameter int INIT_A1  = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIDTH_A1:0]      I_data,
  input  logic                   I_valid,
  output logic                   I_ready,
  output logic                   O_a0,
  output logic [WIDTH_A1-1:0]    O_a1,
  output logic                   O_valid,
  input  logic                   O_ready,
  output logic                   last_a0,
  output logic [WIDTH_A1-1:0]    last_a1,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH_A1-1:0] a1;
    logic                a0;
  } tuple_t;

  tuple_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  tuple_t        last_q, last_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  tuple_t        head;

  assign I_ready = (count_q != FULL);
  assign O_valid = (count_q != '0);
  assign push    = I_valid & I_ready;
  assign pop     = O_valid & O_ready;
  assign head    = mem_q[rptr_q];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    last_d     = last_q;
    overflow_d = overflow_q | (I_valid & ~I_ready);
    // DEPTH is a power of two, so pointer wrap is plain binary overflow
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
      last_d = head;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      last_q.a0  <= 1'(INIT_A0);
      last_q.a1  <= WIDTH_A1'(INIT_A1);
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem_q[wptr_q] <= I_data;
    end
  end

  assign O_a0     = head.a0;
  assign O_a1     = head.a1;
  assign last_a0  = last_q.a0;
  assign last_a1  = last_q.a1;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_product_stream_unpacker.sv
// Scoreboarded bench: queue-based reference model of the FIFO, monitor compares every cycle.
`timescale 1ns/100ps
module tb_product_stream_unpacker;
  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W:0]   I_data = '0;
  logic         I_valid = 1'b0;
  logic         I_ready;
  logic         O_a0;
  logic [W-1:0] O_a1;
  logic         O_valid;
  logic         O_ready = 1'b0;
  logic         last_a0;
  logic [W-1:0] last_a1;
  logic [$clog2(DEPTH):0] count;
  logic         overflow;

  product_stream_unpacker #(.WIDTH_A1(W), .DEPTH(DEPTH), .INIT_A0(1), .INIT_A1(2)) dut (
    .CLK(CLK), .RESET(RESET), .I_data(I_data), .I_valid(I_valid), .I_ready(I_ready),
    .O_a0(O_a0), .O_a1(O_a1), .O_valid(O_valid), .O_ready(O_ready),
    .last_a0(last_a0), .last_a1(last_a1), .count(count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model state: queue of accepted words plus last/overflow registers.
  logic [W:0] exp_q [$];
  logic [W:0] exp_last;
  bit         exp_ovf;
  bit         started;
  int         compared;
  int         mismatched;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled mid-cycle, compared with the model's post-edge state.
  initial begin
    forever begin
      @(negedge CLK);
      if (started) begin
        logic [W:0] h;
        chk("count",    32'(count),    32'(exp_q.size()));
        chk("I_ready",  32'(I_ready),  32'(exp_q.size() != DEPTH));
        chk("O_valid",  32'(O_valid),  32'(exp_q.size() != 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("last_a0",  32'(last_a0),  32'(exp_last[0]));
        chk("last_a1",  32'(last_a1),  32'(exp_last[W:1]));
        if (O_valid && exp_q.size() != 0) begin
          h = exp_q[0];
          chk("O_a0", 32'(O_a0), 32'(h[0]));
          chk("O_a1", 32'(O_a1), 32'(h[W:1]));
        end
      end
    end
  end

  // Model update: decides what the coming edge does from the inputs held this cycle.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (RESET) begin
        exp_q.delete();
        exp_last = {8'h02, 1'b1};
        exp_ovf  = 1'b0;
        started  = 1'b1;
      end else if (started) begin
        bit acc, take;
        acc  = I_valid && (exp_q.size() < DEPTH);
        take = O_ready && (exp_q.size() > 0);
        if (I_valid && exp_q.size() == DEPTH) exp_ovf = 1'b1;
        if (take) exp_last = exp_q.pop_front();
        if (acc) exp_q.push_back(I_data);
      end
    end
  end

  task automatic drive(input bit rst, input bit iv, input logic [W:0] d, input bit ordy);
    @(posedge CLK);
    #1;
    RESET   = rst;
    I_valid = iv;
    I_data  = d;
    O_ready = ordy;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    started    = 1'b0;
    // 1: reset then idle
    drive(1, 0, '0, 0);
    drive(1, 0, '0, 0);
    repeat (2) drive(0, 0, '0, 0);
    // 2: single push, held head, single pop
    drive(0, 1, 9'h0FF, 0);
    drive(0, 0, '0, 0);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    // 3: fill, rejected word sets overflow, drain
    drive(0, 1, 9'h100, 0);
    drive(0, 1, 9'h003, 0);
    drive(0, 1, 9'h1FE, 0);
    drive(0, 1, 9'h1FE, 0);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    // 4: continuous streaming across pointer wrap
    for (int i = 0; i < 10; i++) drive(0, 1, 9'(i), 1);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    // 5: reset coincident with a pop on a full FIFO
    drive(0, 1, 9'h055, 0);
    drive(0, 1, 9'h0AA, 0);
    drive(1, 0, '0, 1);
    drive(0, 0, '0, 0);
    // 6: full with pop and offered word; accepted only after the slot frees
    drive(0, 1, 9'h011, 0);
    drive(0, 1, 9'h022, 0);
    drive(0, 1, 9'h133, 1);
    drive(0, 1, 9'h133, 0);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
            9'($urandom), ($urandom_range(0, 2) != 0));
    end
    repeat (3) drive(0, 0, '0, 1);
    @(negedge CLK);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
